// File: rtl/core_id_reg_ctrl.sv
// Write-port arbiter and long-latency hazard scoreboard for the ID-stage register file.
// Optional operand forwarding from the write port: define CORE_REG_CTRL_BYPASS_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | zeroing x0..x31 through the write port, ID held in stall
// ST_RUN  | wb/lu arbitration, pending scoreboard and stall generation
module core_id_reg_ctrl #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic        id_rs1_used,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_valid,
  input  logic        id_long,
  output logic        id_stall,
  input  logic [31:0] rf_rd0_data,
  input  logic [31:0] rf_rd1_data,
  output logic [31:0] id_rs1_data,
  output logic [31:0] id_rs2_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_write_en,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       clr_idx;
  logic [4:0]       clr_idx_nxt;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] raw_pend;

  logic        in_run;
  logic        sel_valid;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        lu_xfer;
  logic        raw_hit;
  logic        waw_hit;
  logic        coll_hit;
  logic        issue_long;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_idx <= 5'd0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    clr_idx_nxt   = clr_idx;
    sel_valid     = 1'b0;
    sel_addr      = 5'd0;
    sel_data      = 32'd0;
    lu_ready      = 1'b0;
    rf_write_en   = 1'b0;
    rf_write_addr = 5'd0;
    rf_write_data = 32'd0;
    case (state)
      ST_INIT: begin
        rf_write_en   = 1'b1;
        rf_write_addr = clr_idx;
        clr_idx_nxt   = clr_idx + 5'd1;
        if (clr_idx == 5'd31) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Writeback has no ready, so it always owns the port when present.
        lu_ready = ~wb_valid;
        if (wb_valid) begin
          sel_valid = 1'b1;
          sel_addr  = wb_addr;
          sel_data  = wb_data;
        end else if (lu_valid) begin
          sel_valid = 1'b1;
          sel_addr  = lu_addr;
          sel_data  = lu_data;
        end
        rf_write_en   = sel_valid & (sel_addr != 5'd0);
        rf_write_addr = sel_addr;
        rf_write_data = sel_data;
      end
      default: begin
        state_nxt   = ST_INIT;
        clr_idx_nxt = 5'd0;
      end
    endcase
  end

  assign in_run  = (state == ST_RUN);
  assign lu_xfer = lu_valid & lu_ready;

  always_comb begin
    clr_mask = '0;
    if (lu_xfer) begin
      clr_mask = {{(NREGS-1){1'b0}}, 1'b1} << lu_addr;
    end
  end

`ifdef CORE_REG_CTRL_BYPASS_EN
  // A result landing this cycle is forwarded, so its pending bit no longer blocks readers.
  assign raw_pend = pending & ~clr_mask;
  assign coll_hit = 1'b0;

  assign id_rs1_data = (rf_write_en && (rf_write_addr == id_rs1_addr)) ? rf_write_data
                                                                       : rf_rd0_data;
  assign id_rs2_data = (rf_write_en && (rf_write_addr == id_rs2_addr)) ? rf_write_data
                                                                       : rf_rd1_data;
`else
  assign raw_pend = pending;
  // Without forwarding, a reader of the register being written waits one cycle.
  assign coll_hit = rf_write_en &
                    ((id_rs1_used & (id_rs1_addr == rf_write_addr)) |
                     (id_rs2_used & (id_rs2_addr == rf_write_addr)));

  assign id_rs1_data = rf_rd0_data;
  assign id_rs2_data = rf_rd1_data;
`endif

  assign raw_hit = (id_rs1_used & (id_rs1_addr != 5'd0) & raw_pend[id_rs1_addr]) |
                   (id_rs2_used & (id_rs2_addr != 5'd0) & raw_pend[id_rs2_addr]);
  assign waw_hit = id_valid & (id_rd_addr != 5'd0) & pending[id_rd_addr];

  assign id_stall = in_run ? (id_valid & (raw_hit | waw_hit | coll_hit)) : 1'b1;

  assign issue_long = in_run & id_valid & id_long & ~id_stall & (id_rd_addr != 5'd0);

  always_comb begin
    set_mask = '0;
    if (issue_long) begin
      set_mask = {{(NREGS-1){1'b0}}, 1'b1} << id_rd_addr;
    end
  end

  // Set is applied after clear so a same-register race leaves the bit pending.
  always_comb begin
    pending_nxt    = (pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

endmodule

// File: tb/tb_core_id_reg_ctrl.sv
// Self-checking bench for core_id_reg_ctrl: vector table, directed corner sequences
// and randomized traffic against a register/scoreboard reference model.
module tb_core_id_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rs1_used, id_rs2_used, id_valid, id_long;
  logic        id_stall;
  logic [31:0] rf_rd0_data, rf_rd1_data, id_rs1_data, id_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  always #5 clk = ~clk;

  core_id_reg_ctrl #(.NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_valid(id_valid), .id_long(id_long),
    .id_stall(id_stall),
    .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data)
  );

  // Register file with no reset, attached to the DUT's write port.
  logic [31:0] tb_rf [32];
  always @(posedge clk) if (rf_write_en === 1'b1) tb_rf[rf_write_addr] <= rf_write_data;
  assign rf_rd0_data = tb_rf[id_rs1_addr];
  assign rf_rd1_data = tb_rf[id_rs2_addr];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_init;
  int          m_clr;
  bit          m_pend [32];
  logic [31:0] m_rf   [32];
  // Expected outputs for the current cycle
  bit          e_stall, e_lrdy, e_we;
  logic [4:0]  e_wa;
  logic [31:0] e_wd, e_rs1, e_rs2;

  typedef struct {
    bit          wb_v;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    bit          lu_v;
    logic [4:0]  lu_a;
    logic [31:0] lu_d;
    bit          x_we;
    logic [4:0]  x_wa;
    logic [31:0] x_wd;
    bit          x_lrdy;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit raw1, raw2, waw, coll;
    if (m_init) begin
      e_stall = 1'b1; e_lrdy = 1'b0; e_we = 1'b1; e_wa = m_clr[4:0]; e_wd = 32'd0;
    end else begin
      e_lrdy = !wb_valid;
      if (wb_valid)      begin e_we = (wb_addr != 0); e_wa = wb_addr; e_wd = wb_data; end
      else if (lu_valid) begin e_we = (lu_addr != 0); e_wa = lu_addr; e_wd = lu_data; end
      else               begin e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0; end
      raw1 = id_rs1_used && id_rs1_addr != 0 && m_pend[id_rs1_addr];
      raw2 = id_rs2_used && id_rs2_addr != 0 && m_pend[id_rs2_addr];
`ifdef CORE_REG_CTRL_BYPASS_EN
      raw1 = raw1 && !(lu_valid && e_lrdy && lu_addr == id_rs1_addr);
      raw2 = raw2 && !(lu_valid && e_lrdy && lu_addr == id_rs2_addr);
      coll = 1'b0;
`else
      coll = e_we && ((id_rs1_used && id_rs1_addr == e_wa) || (id_rs2_used && id_rs2_addr == e_wa));
`endif
      waw = id_rd_addr != 0 && m_pend[id_rd_addr];
      e_stall = id_valid && (raw1 || raw2 || waw || coll);
    end
`ifdef CORE_REG_CTRL_BYPASS_EN
    e_rs1 = (e_we && e_wa == id_rs1_addr) ? e_wd : m_rf[id_rs1_addr];
    e_rs2 = (e_we && e_wa == id_rs2_addr) ? e_wd : m_rf[id_rs2_addr];
`else
    e_rs1 = m_rf[id_rs1_addr];
    e_rs2 = m_rf[id_rs2_addr];
`endif
  endtask

  task automatic model_update();
    if (e_we) m_rf[e_wa] = e_wd;
    if (rst) begin
      m_init = 1'b1; m_clr = 0;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else if (m_init) begin
      if (m_clr == 31) m_init = 1'b0;
      m_clr = (m_clr + 1) % 32;
    end else begin
      if (lu_valid && e_lrdy) m_pend[lu_addr] = 1'b0;
      if (id_valid && id_long && !e_stall && id_rd_addr != 0) m_pend[id_rd_addr] = 1'b1;
    end
  endtask

  task automatic eval_cycle();
    @(negedge clk);
    model_eval();
    check("id_stall", 32'(id_stall), 32'(e_stall));
    check("lu_ready", 32'(lu_ready), 32'(e_lrdy));
    check("rf_write_en", 32'(rf_write_en), 32'(e_we));
    if (e_we) begin
      check("rf_write_addr", 32'(rf_write_addr), 32'(e_wa));
      check("rf_write_data", rf_write_data, e_wd);
    end
    if (!m_init) begin
      check("id_rs1_data", id_rs1_data, e_rs1);
      check("id_rs2_data", id_rs2_data, e_rs2);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_valid = 0; id_long = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0;
  endtask

  task automatic clear_sequence(input string tag);
    for (int i = 0; i < 32; i++) begin
      eval_cycle();
      check({tag, "_we"}, 32'(rf_write_en), 32'd1);
      check({tag, "_addr"}, 32'(rf_write_addr), 32'(i));
      check({tag, "_data"}, rf_write_data, 32'd0);
      check({tag, "_stall"}, 32'(id_stall), 32'd1);
      check({tag, "_lu_ready"}, 32'(lu_ready), 32'd0);
      advance();
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,        1'b1};
    vecs[1] = '{1'b1, 5'd3,  32'h0000_00A5, 1'b0, 5'd0,  32'h0,      1'b1, 5'd3,  32'h0000_00A5, 1'b0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h1234,   1'b1, 5'd12, 32'h1234,     1'b1};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd1,  32'h55,     1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{1'b1, 5'd0,  32'h77,       1'b1, 5'd8,  32'h66,     1'b0, 5'd0,  32'h0,        1'b0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h99,     1'b0, 5'd0,  32'h0,        1'b1};
    vecs[6] = '{1'b1, 5'd17, 32'h0,        1'b0, 5'd2,  32'h44,     1'b1, 5'd17, 32'h0,        1'b0};

    for (int i = 0; i < 32; i++) begin
      tb_rf[i] = $urandom;
      m_rf[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    m_init = 1'b1; m_clr = 0;
    #1 rst = 1'b0;

    // Clearing sequence after reset, then idle RUN
    clear_sequence("clr");
    id_valid = 1;
    eval_cycle();
    check("idle_stall", 32'(id_stall), 32'd0);
    advance();

    // Arbitration vector table
    for (int v = 0; v < 7; v++) begin
      idle();
      wb_valid = vecs[v].wb_v; wb_addr = vecs[v].wb_a; wb_data = vecs[v].wb_d;
      lu_valid = vecs[v].lu_v; lu_addr = vecs[v].lu_a; lu_data = vecs[v].lu_d;
      eval_cycle();
      check($sformatf("vec%0d_we", v), 32'(rf_write_en), 32'(vecs[v].x_we));
      check($sformatf("vec%0d_lu_ready", v), 32'(lu_ready), 32'(vecs[v].x_lrdy));
      if (vecs[v].x_we) begin
        check($sformatf("vec%0d_addr", v), 32'(rf_write_addr), 32'(vecs[v].x_wa));
        check($sformatf("vec%0d_data", v), rf_write_data, vecs[v].x_wd);
      end
      advance();
    end

    // Long-op RAW on x5
    idle(); id_valid = 1; id_long = 1; id_rd_addr = 5;
    eval_cycle(); check("raw_issue_stall", 32'(id_stall), 32'd0); advance();
    idle(); id_valid = 1; id_rd_addr = 6; id_rs1_addr = 5; id_rs1_used = 1;
    repeat (2) begin eval_cycle(); check("raw_wait_stall", 32'(id_stall), 32'd1); advance(); end
    lu_valid = 1; lu_addr = 5; lu_data = 32'hDEAD_BEEF;
    eval_cycle();
    check("raw_lu_ready", 32'(lu_ready), 32'd1);
`ifdef CORE_REG_CTRL_BYPASS_EN
    check("raw_done_stall", 32'(id_stall), 32'd0);
    check("raw_fwd_data", id_rs1_data, 32'hDEAD_BEEF);
`else
    check("raw_done_stall", 32'(id_stall), 32'd1);
`endif
    advance();
    lu_valid = 0;
    eval_cycle();
    check("raw_after_stall", 32'(id_stall), 32'd0);
    check("raw_after_data", id_rs1_data, 32'hDEAD_BEEF);
    advance();

    // Port contention
    idle(); wb_valid = 1; wb_addr = 3; wb_data = 32'h11; lu_valid = 1; lu_addr = 7; lu_data = 32'h22;
    eval_cycle();
    check("cont_addr", 32'(rf_write_addr), 32'd3);
    check("cont_data", rf_write_data, 32'h11);
    check("cont_lu_ready", 32'(lu_ready), 32'd0);
    advance();
    wb_valid = 0;
    eval_cycle();
    check("cont_lu_addr", 32'(rf_write_addr), 32'd7);
    check("cont_lu_data", rf_write_data, 32'h22);
    check("cont_lu_ready2", 32'(lu_ready), 32'd1);
    advance();
    idle(); id_valid = 1; id_rs1_used = 1; id_rs1_addr = 3; id_rs2_used = 1; id_rs2_addr = 7;
    eval_cycle();
    check("cont_rd_x3", id_rs1_data, 32'h11);
    check("cont_rd_x7", id_rs2_data, 32'h22);
    check("cont_no_stall", 32'(id_stall), 32'd0);
    advance();

    // x0 handling
    idle(); wb_valid = 1; wb_addr = 0; wb_data = 32'h77;
    eval_cycle(); check("x0_wb_we", 32'(rf_write_en), 32'd0); advance();
    idle(); id_valid = 1; id_long = 1; id_rd_addr = 0;
    eval_cycle(); check("x0_issue_stall", 32'(id_stall), 32'd0); advance();
    idle(); id_valid = 1; id_rs1_used = 1; id_rs1_addr = 0;
    eval_cycle(); check("x0_rs1_stall", 32'(id_stall), 32'd0); advance();

    // Set/clear race on x9
    idle(); id_valid = 1; id_long = 1; id_rd_addr = 9; lu_valid = 1; lu_addr = 9; lu_data = 32'h99;
    eval_cycle(); check("race_stall", 32'(id_stall), 32'd0); advance();
    idle(); id_valid = 1; id_rs1_used = 1; id_rs1_addr = 9;
    eval_cycle(); check("race_pending", 32'(id_stall), 32'd1); advance();
    idle(); lu_valid = 1; lu_addr = 9; lu_data = 32'h1999;
    eval_cycle(); advance();

    // Reset mid-flight with x4 pending
    idle(); id_valid = 1; id_long = 1; id_rd_addr = 4;
    eval_cycle(); advance();
    idle(); id_valid = 1; id_rs1_used = 1; id_rs1_addr = 4;
    eval_cycle(); check("mid_pending", 32'(id_stall), 32'd1); advance();
    idle(); rst = 1;
    eval_cycle(); advance();
    rst = 0;
    clear_sequence("reclr");
    id_valid = 1; id_rs1_used = 1; id_rs1_addr = 4;
    eval_cycle(); check("mid_after_stall", 32'(id_stall), 32'd0); advance();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 399) == 0);
      id_valid    = $urandom_range(0, 1);
      id_long     = ($urandom_range(0, 2) == 0);
      id_rd_addr  = 5'($urandom_range(0, 7));
      id_rs1_addr = 5'($urandom_range(0, 7));
      id_rs2_addr = 5'($urandom_range(0, 7));
      id_rs1_used = $urandom_range(0, 1);
      id_rs2_used = $urandom_range(0, 1);
      wb_valid    = ($urandom_range(0, 3) == 0);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      lu_valid    = ($urandom_range(0, 2) == 0);
      lu_addr     = 5'($urandom_range(0, 7));
      lu_data     = $urandom;
      eval_cycle();
      advance();
    end
    rst = 0; idle();
    repeat (40) begin eval_cycle(); advance(); end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
